lsu_unit: RTL

- Load/store unit between the core's execute stage and the memory map (ROM at 0x0000_0000, RAM at 0x1000_0000, GPIO at 0x2000_0000).
- Accepts one request at a time through a valid/ready handshake and decodes RISC-V funct3.
- Drives the memory bus: address, one-hot write enable, write data.
- Extracts and sign- or zero-extends load data, and returns a one-cycle response.

---
 rtl/lsu_unit.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/lsu_unit.sv
// lsu_unit: load/store unit bridging the execute stage to the ROM/RAM/GPIO memory map.
// Optional macro LSU_MISALIGNED_SPLIT_EN splits misaligned half/word accesses into byte beats.
module lsu_unit #(
   parameter int ADDR_W = 32,
   parameter int XLEN   = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [XLEN-1:0]   req_wdata,
   output logic              resp_valid,
   output logic [XLEN-1:0]   resp_rdata,
   output logic              resp_fault,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [2:0]        mem_write_enable,
   output logic [XLEN-1:0]   mem_data_in,
   input  logic [XLEN-1:0]   mem_data_out
);
   typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

   state_t            state_r, state_nxt_s;
   logic              write_r, fault_r, split_r;
   logic [2:0]        funct3_r;
   logic [ADDR_W-1:0] addr_r;
   logic [XLEN-1:0]   wdata_r, rdata_r;
   logic [1:0]        beat_r, last_r;

   logic              accept_s, legal_s, aligned_s, fault_s, split_s;
   logic [1:0]        last_s;
   logic [4:0]        sh_s;
   logic [XLEN-1:0]   raw_s;

   function automatic logic f_legal(input logic wr, input logic [2:0] f3);
      logic ok;
      case (f3)
         3'b000, 3'b001, 3'b010: ok = 1'b1;
         3'b100, 3'b101:         ok = !wr;
         default:                ok = 1'b0;
      endcase
      return ok;
   endfunction

   function automatic logic f_aligned(input logic [2:0] f3, input logic [1:0] a);
      logic ok;
      case (f3[1:0])
         2'b01:   ok = (a[0] == 1'b0);
         2'b10:   ok = (a == 2'b00);
         default: ok = 1'b1;
      endcase
      return ok;
   endfunction

   function automatic logic [XLEN-1:0] f_extend(input logic [2:0] f3, input logic [XLEN-1:0] d);
      logic [XLEN-1:0] r;
      case (f3)
         3'b000:  r = {{(XLEN-8){d[7]}}, d[7:0]};
         3'b001:  r = {{(XLEN-16){d[15]}}, d[15:0]};
         3'b100:  r = {{(XLEN-8){1'b0}}, d[7:0]};
         3'b101:  r = {{(XLEN-16){1'b0}}, d[15:0]};
         default: r = d;
      endcase
      return r;
   endfunction

   // Request decode and split-load byte assembly.
   always_comb begin
      accept_s  = req_valid && (state_r == IDLE);
      legal_s   = f_legal(req_write, req_funct3);
      aligned_s = f_aligned(req_funct3, req_addr[1:0]);
`ifdef LSU_MISALIGNED_SPLIT_EN
      fault_s = !legal_s;
      split_s = legal_s && !aligned_s;
`else
      fault_s = !legal_s || !aligned_s;
      split_s = 1'b0;
`endif
      if (!split_s) begin
         last_s = 2'd0;
      end else if (req_funct3[1:0] == 2'b01) begin
         last_s = 2'd1;
      end else begin
         last_s = 2'd3;
      end
      sh_s = {beat_r, 3'b000};
      if (split_r) begin
         raw_s = (rdata_r & ~(XLEN'(8'hFF) << sh_s)) | (XLEN'(mem_data_out[7:0]) << sh_s);
      end else begin
         raw_s = mem_data_out;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               state_nxt_s = fault_s ? RESP : ACCESS;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         ACCESS: begin
            if (beat_r == last_r) begin
               state_nxt_s = RESP;
            end else begin
               state_nxt_s = ACCESS;
            end
         end
         RESP:    state_nxt_s = IDLE;
         default: state_nxt_s = IDLE;
      endcase
   end

   // Outputs decoded from registered state; the bus is idle outside ACCESS.
   always_comb begin
      req_ready        = 1'b0;
      resp_valid       = 1'b0;
      resp_rdata       = '0;
      resp_fault       = 1'b0;
      mem_addr         = '0;
      mem_write_enable = 3'b000;
      mem_data_in      = '0;
      case (state_r)
         IDLE: req_ready = 1'b1;
         ACCESS: begin
            mem_addr = addr_r + ADDR_W'(beat_r);
            if (split_r) begin
               mem_data_in = XLEN'(8'(wdata_r >> sh_s));
            end else begin
               mem_data_in = wdata_r;
            end
            if (!write_r) begin
               mem_write_enable = 3'b000;
            end else if (split_r) begin
               mem_write_enable = 3'b100;
            end else begin
               case (funct3_r[1:0])
                  2'b00:   mem_write_enable = 3'b100;
                  2'b01:   mem_write_enable = 3'b010;
                  2'b10:   mem_write_enable = 3'b001;
                  default: mem_write_enable = 3'b000;
               endcase
            end
         end
         RESP: begin
            resp_valid = 1'b1;
            resp_rdata = rdata_r;
            resp_fault = fault_r;
         end
         default: req_ready = 1'b0;
      endcase
   end

   // Request capture, beat counting and load data collection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         write_r  <= 1'b0;
         fault_r  <= 1'b0;
         split_r  <= 1'b0;
         funct3_r <= 3'b000;
         addr_r   <= '0;
         wdata_r  <= '0;
         rdata_r  <= '0;
         beat_r   <= 2'd0;
         last_r   <= 2'd0;
      end else begin
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  write_r  <= req_write;
                  fault_r  <= fault_s;
                  split_r  <= split_s;
                  funct3_r <= req_funct3;
                  addr_r   <= req_addr;
                  wdata_r  <= req_wdata;
                  rdata_r  <= '0;
                  beat_r   <= 2'd0;
                  last_r   <= last_s;
               end
            end
            ACCESS: begin
               // Extension is applied only once every byte has been assembled.
               if (!write_r) begin
                  rdata_r <= (beat_r == last_r) ? f_extend(funct3_r, raw_s) : raw_s;
               end
               if (beat_r != last_r) begin
                  beat_r <= beat_r + 2'd1;
               end
            end
            default: beat_r <= beat_r;
         endcase
      end
   end
endmodule
